// File: rtl/cpu_bus_responder.sv
// CPU bus responder: decodes strobed CPU accesses into single-cycle backing-memory
// read/write requests and returns registered read data to the CPU.
module cpu_bus_responder #(
    parameter logic [7:0] CART_ABSENT_DATA = 8'hFF
) (
    input  logic        CLK,
    input  logic        RESETB,
    input  logic [15:0] A,
    input  logic        RDB,
    input  logic        WRB,
    input  logic [7:0]  CPU_DB_O,
    output logic [7:0]  CPU_DB_I,
    output logic [1:0]  MEM_SEL,
    output logic [15:0] MEM_ADDR,
    output logic        MEM_RE,
    output logic        MEM_WE,
    output logic [7:0]  MEM_WDATA,
    input  logic [7:0]  MEM_RDATA,
    input  logic        CART_PRESENT,
    output logic        BUS_ERR
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RD_REQ    = 3'd1;
    localparam logic [2:0] ST_RD_DATA   = 3'd2;
    localparam logic [2:0] ST_RD_HOLD   = 3'd3;
    localparam logic [2:0] ST_WR_HOLD   = 3'd4;
    localparam logic [2:0] ST_WR_COMMIT = 3'd5;

    localparam logic [1:0] SEL_ROM  = 2'd0;
    localparam logic [1:0] SEL_WRAM = 2'd1;
    localparam logic [1:0] SEL_VRAM = 2'd2;
    localparam logic [1:0] SEL_CART = 2'd3;

    logic [2:0]  state_reg, state_next;
    logic [15:0] addr_reg;
    logic [1:0]  sel_reg;
    logic        req_issued_reg;
    logic        re_reg;
    logic        we_reg;
    logic [7:0]  wdata_reg;
    logic [7:0]  rdata_reg;
    logic        err_reg;
    logic        err_set;

    logic        is_rom, is_vram, is_wram, is_cart;
    logic        dec_mapped;
    logic [1:0]  dec_sel;
    logic        rd_ok;
    logic        wr_ok;
    logic        start_rd, start_wr, start_commit;

    // Address decode on the live bus; only used at the strobe-detection edge.
    always_comb begin
        is_rom     = (A[15:12] == 4'h0);
        is_vram    = (A[15:10] == 6'b0011_00);
        is_wram    = (A[15:7] == 9'h1FF);
        is_cart    = A[15] && !is_wram;
        dec_mapped = is_rom || is_vram || is_wram || is_cart;
        dec_sel    = SEL_ROM;
        if (is_wram)
            dec_sel = SEL_WRAM;
        else if (is_vram)
            dec_sel = SEL_VRAM;
        else if (is_cart)
            dec_sel = SEL_CART;
    end

    // Unmapped addresses share select 0 with ROM; both are non-writable, so the
    // write permission check can rely on the select alone.
    assign rd_ok = dec_mapped && !(dec_sel == SEL_CART && !CART_PRESENT);
    assign wr_ok = (sel_reg == SEL_WRAM) || (sel_reg == SEL_VRAM) ||
                   (sel_reg == SEL_CART && CART_PRESENT);

    always_comb begin
        state_next = state_reg;
        err_set    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!RDB && !WRB)
                    err_set = 1'b1;
                else if (!RDB)
                    state_next = ST_RD_REQ;
                else if (!WRB)
                    state_next = ST_WR_HOLD;
            end
            ST_RD_REQ: begin
                err_set    = !WRB;
                state_next = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                err_set    = !WRB;
                state_next = ST_RD_HOLD;
            end
            ST_RD_HOLD: begin
                err_set = !WRB;
                if (RDB)
                    state_next = ST_IDLE;
            end
            ST_WR_HOLD: begin
                err_set = !RDB;
                if (WRB)
                    state_next = ST_WR_COMMIT;
            end
            ST_WR_COMMIT: state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    assign start_rd     = (state_reg == ST_IDLE) && (state_next == ST_RD_REQ);
    assign start_wr     = (state_reg == ST_IDLE) && (state_next == ST_WR_HOLD);
    assign start_commit = (state_reg == ST_WR_HOLD) && (state_next == ST_WR_COMMIT);

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= 16'h0000;
            sel_reg        <= SEL_ROM;
            req_issued_reg <= 1'b0;
            re_reg         <= 1'b0;
            we_reg         <= 1'b0;
            wdata_reg      <= 8'h00;
            rdata_reg      <= 8'hFF;
            err_reg        <= 1'b0;
        end else begin
            state_reg <= state_next;
            re_reg    <= start_rd && rd_ok;
            we_reg    <= start_commit && wr_ok;
            if (err_set)
                err_reg <= 1'b1;
            if (start_rd || start_wr) begin
                addr_reg <= A;
                sel_reg  <= dec_sel;
            end
            if (start_rd)
                req_issued_reg <= rd_ok;
            if (start_wr || (state_reg == ST_WR_HOLD && !WRB))
                wdata_reg <= CPU_DB_O;
            if (state_reg == ST_RD_DATA)
                rdata_reg <= req_issued_reg ? MEM_RDATA : CART_ABSENT_DATA;
        end
    end

    assign CPU_DB_I  = rdata_reg;
    assign MEM_SEL   = sel_reg;
    assign MEM_ADDR  = addr_reg;
    assign MEM_RE    = re_reg;
    assign MEM_WE    = we_reg;
    assign MEM_WDATA = wdata_reg;
    assign BUS_ERR   = err_reg;

endmodule

// File: doc/cpu_bus_responder.md
CPU_BUS_RESPONDER -- requirements
Module: cpu_bus_responder

Interface
REQ-001 SHALL have parameter CART_ABSENT_DATA, default 8'hFF, the read data returned for cart-region reads with no cart present and for unmapped reads.
REQ-002 SHALL have port CLK, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port RESETB, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port A, input, 16, CPU address.
REQ-005 SHALL have port RDB, input, 1, CPU read strobe, active low.
REQ-006 SHALL have port WRB, input, 1, CPU write strobe, active low.
REQ-007 SHALL have port CPU_DB_O, input, 8, CPU write data.
REQ-008 SHALL have port CPU_DB_I, output, 8, registered read data to the CPU.
REQ-009 SHALL have port MEM_SEL, output, 2, region select: 0 ROM, 1 WRAM, 2 VRAM, 3 CART.
REQ-010 SHALL have port MEM_ADDR, output, 16, latched CPU address.
REQ-011 SHALL have port MEM_RE, output, 1, one-cycle backing-memory read request.
REQ-012 SHALL have port MEM_WE, output, 1, one-cycle backing-memory write request.
REQ-013 SHALL have port MEM_WDATA, output, 8, write data.
REQ-014 SHALL have port MEM_RDATA, input, 8, backing-memory read data, valid exactly one cycle after MEM_RE.
REQ-015 SHALL have port CART_PRESENT, input, 1, cart inserted.
REQ-016 SHALL have port BUS_ERR, output, 1, sticky protocol-error flag.

Function
REQ-017 Decode, from A latched at strobe detection: ROM 16'h0000-0FFF; VRAM 16'h3000-33FF; WRAM 16'hFF80-FFFF; CART A[15]=1 and not WRAM; anything else unmapped.
REQ-018 States: IDLE, RD_REQ, RD_DATA, RD_HOLD, WR_HOLD, WR_COMMIT.
REQ-019 IDLE: RDB=0 with WRB=1 sampled -> latch A and MEM_SEL, go RD_REQ; WRB=0 with RDB=1 -> latch A and MEM_SEL, go WR_HOLD; both low -> set BUS_ERR, stay IDLE, no access.
REQ-020 RD_REQ: MEM_RE=1 for exactly this cycle if the region is mapped and not (CART with CART_PRESENT=0); else MEM_RE=0; next state RD_DATA.
REQ-021 RD_DATA: at its closing edge, load CPU_DB_I with MEM_RDATA if a request was issued, else CART_ABSENT_DATA; next state RD_HOLD.
REQ-022 Read latency: CPU_DB_I is valid 3 rising edges after the edge that first samples RDB=0.
REQ-023 RD_HOLD: CPU_DB_I held; RDB sampled 1 -> IDLE; if the CPU releases RDB before RD_HOLD, the sequence still completes, then IDLE.
REQ-024 CPU_DB_I SHALL hold its last loaded value in every state except the closing edge of RD_DATA.
REQ-025 WR_HOLD: MEM_WDATA captures CPU_DB_O on every edge with WRB=0; on the first edge sampling WRB=1, go WR_COMMIT.
REQ-026 WR_COMMIT: MEM_WE=1 for exactly this cycle, with MEM_ADDR/MEM_WDATA/MEM_SEL stable, only for WRAM, VRAM, or CART with CART_PRESENT=1; ROM and unmapped writes are dropped silently; next IDLE.
REQ-027 RDB going low in WR_HOLD or WRB going low in any read state SHALL set BUS_ERR; the operation in progress still completes normally.
REQ-028 MEM_RE and MEM_WE are never high in the same cycle, and each is high for at most one cycle per CPU strobe.
REQ-029 BUS_ERR, once set, stays set until reset.

Reset
REQ-030 RESETB=0 SHALL immediately force: state IDLE, CPU_DB_I=8'hFF, MEM_RE=0, MEM_WE=0, MEM_SEL=0, MEM_ADDR=0, MEM_WDATA=0, BUS_ERR=0.
REQ-031 Reset during any state SHALL abort the operation; a pending write is never committed.
REQ-032 After RESETB deasserts, a strobe already low SHALL be treated as a new access from IDLE.

Verification
REQ-033 ROM read at A=16'h0016 with MEM_RDATA=8'hA5 the cycle after MEM_RE -> MEM_SEL=0, one MEM_RE pulse, CPU_DB_I=8'hA5 by edge 3, held until RDB high.
REQ-034 WRAM write at A=16'hFF90 with data 8'h3C, WRB low 4 cycles -> single MEM_WE pulse one cycle after WRB rises, MEM_SEL=1, MEM_ADDR=16'hFF90, MEM_WDATA=8'h3C.
REQ-035 Cart read at A=16'h8000 with CART_PRESENT=0 -> no MEM_RE, CPU_DB_I=8'hFF; write to A=16'h0100 -> no MEM_WE.
REQ-036 RDB and WRB low together in IDLE -> BUS_ERR=1, no MEM_RE or MEM_WE, BUS_ERR held across later good accesses.
REQ-037 RESETB pulsed low during WR_HOLD at VRAM A=16'h3200 -> no MEM_WE ever issued, all outputs at reset values.
REQ-038 Back-to-back read of A=16'h33FF then read of A=16'h3400 -> first MEM_SEL=2 with MEM_RE, second unmapped with CPU_DB_I=8'hFF and no MEM_RE.
